// File: rtl/wshb_ram_slave.sv
// Wishbone B4 slave backed by a 32-bit on-chip word memory.
// Serves classic single accesses and registered-feedback incrementing linear bursts.
module wshb_ram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST
  } state_t;

  state_t            state_q, state_d;
  logic              ack_r_q, ack_r_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       dat_sm_q;

  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] word_adr;
  logic [ADDR_W-1:0] cnt_inc;
  logic              beat;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_adr_bits;

  assign word_adr        = adr[ADDR_W+1:2];
  assign unused_adr_bits = ^{adr[31:ADDR_W+2], adr[1:0]};
  assign cnt_inc         = cnt_q + ADDR_W'(1);

  // Qualifying with cyc & stb keeps ack low during master wait states.
  assign beat   = ack_r_q & cyc & stb;
  assign ack    = beat;
  assign dat_sm = dat_sm_q;
  assign err    = 1'b0;
  assign rty    = 1'b0;

  always_comb begin
    state_d = state_q;
    ack_r_d = ack_r_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_addr = word_adr;
    wr_en   = 1'b0;
    wr_addr = word_adr;

    unique case (state_q)
      IDLE: begin
        if (cyc && stb && !ack_r_q) begin
          ack_r_d = 1'b1;
          rd_en   = 1'b1;
          if (cti == CTI_INCR && bte == 2'b00) begin
            state_d = BURST;
            cnt_d   = word_adr;
          end else begin
            state_d = CLASSIC;
          end
        end
      end

      CLASSIC: begin
        if (!cyc) begin
          ack_r_d = 1'b0;
          state_d = IDLE;
        end else if (beat) begin
          wr_en   = we;
          ack_r_d = 1'b0;
          state_d = IDLE;
        end
      end

      BURST: begin
        // The slave tracks the burst address itself; adr is ignored here.
        wr_addr = cnt_q;
        if (!cyc) begin
          ack_r_d = 1'b0;
          state_d = IDLE;
        end else if (beat) begin
          wr_en = we;
          if (cti == CTI_INCR) begin
            cnt_d   = cnt_inc;
            rd_en   = 1'b1;
            rd_addr = cnt_inc;
          end else begin
            ack_r_d = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        ack_r_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_r_q <= ack_r_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered read port; a same-word write on the same edge leaves the old value here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_sm_q <= '0;
    end else if (rd_en) begin
      dat_sm_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[wr_addr][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

endmodule
